// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline sequencing controller.
package pipe_ctrl_pkg;

    typedef enum logic [2:0] {
        RUN   = 3'd0,
        STALL = 3'd1,
        FLUSH = 3'd2,
        DRAIN = 3'd3,
        HALT  = 3'd4
    } pipe_state_t;

    localparam int FLUSH_CYCLES_DEF = 2;
    localparam int DRAIN_CYCLES_DEF = 3;

endpackage

// File: rtl/cyc_down_cnt.sv
// Loadable 3-bit down-counter with zero flag; holds at zero instead of wrapping.
module cyc_down_cnt (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [2:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [2:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 3'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != 3'd0)) begin
            cnt <= cnt - 3'd1;
        end
    end

    assign zero = (cnt == 3'd0);

endmodule

// File: rtl/pipe_seq_ctrl.sv
// Pipeline hazard/flush/halt sequencer driving PC and IF/ID/EX enables.
// Optional PIPE_PERF_CNT_EN adds a saturating stall-cycle counter output.
module pipe_seq_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        data_hazard,
    input  logic        redirect,
    input  logic        halt_dec,
    input  logic        resume,
    output logic        pc_we,
    output logic        if_id_we,
    output logic        if_id_flush,
    output logic        id_ex_bubble,
    output logic        halted,
    output logic [2:0]  state_dbg
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    localparam logic [2:0] FLUSH_LD = 3'(FLUSH_CYCLES - 1);
    localparam logic [2:0] DRAIN_LD = 3'(DRAIN_CYCLES - 1);

    pipe_state_t state, state_nxt;
    logic        cnt_load, cnt_dec, cnt_zero;
    logic [2:0]  cnt_ld_val;
    logic        pc_we_c, if_id_we_c, flush_c, bubble_c, halted_c;

    cyc_down_cnt u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_ld_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        cnt_load   = 1'b0;
        cnt_ld_val = FLUSH_LD;
        cnt_dec    = 1'b0;
        pc_we_c    = 1'b0;
        if_id_we_c = 1'b0;
        flush_c    = 1'b1;
        bubble_c   = 1'b1;
        halted_c   = 1'b0;
        case (state)
            RUN, STALL: begin
                pc_we_c    = redirect | ~data_hazard;
                if_id_we_c = ~data_hazard;
                flush_c    = redirect;
                bubble_c   = redirect | data_hazard;
                if (redirect) begin
                    state_nxt = FLUSH;
                    cnt_load  = 1'b1;
                end else if (state == RUN) begin
                    if (halt_dec) begin
                        state_nxt  = DRAIN;
                        cnt_load   = 1'b1;
                        cnt_ld_val = DRAIN_LD;
                    end else if (data_hazard) begin
                        state_nxt = STALL;
                    end
                end else if (!data_hazard) begin
                    // ID is frozen while stalled, so a HALT seen here re-presents later
                    state_nxt = RUN;
                end
            end
            FLUSH: begin
                pc_we_c    = 1'b1;
                if_id_we_c = 1'b1;
                if (redirect)      cnt_load  = 1'b1;
                else if (cnt_zero) state_nxt = RUN;
                else               cnt_dec   = 1'b1;
            end
            DRAIN: begin
                if (redirect) begin
                    state_nxt = FLUSH;
                    cnt_load  = 1'b1;
                end else if (cnt_zero) begin
                    state_nxt = HALT;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            HALT: begin
                halted_c = 1'b1;
                if (resume) state_nxt = RUN;
            end
            default: begin
                halted_c  = 1'b1;
                state_nxt = RUN;
            end
        endcase
    end

    // Reset overrides the outputs immediately, independent of the clock
    assign pc_we        = rst_n & pc_we_c;
    assign if_id_we     = rst_n & if_id_we_c;
    assign if_id_flush  = ~rst_n | flush_c;
    assign id_ex_bubble = ~rst_n | bubble_c;
    assign halted       = rst_n & halted_c;
    assign state_dbg    = state;

`ifdef PIPE_PERF_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 16'd0;
        end else if (!pc_we && (state != HALT) && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Self-checking bench for pipe_seq_ctrl: directed vector table, reset sequences, random vs model.
module tb_pipe_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       data_hazard = 1'b0, redirect = 1'b0, halt_dec = 1'b0, resume = 1'b0;
    logic       pc_we, if_id_we, if_id_flush, id_ex_bubble, halted;
    logic [2:0] state_dbg;
`ifdef PIPE_PERF_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int checks = 0;
    int failures = 0;

    pipe_seq_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_hazard  (data_hazard),
        .redirect     (redirect),
        .halt_dec     (halt_dec),
        .resume       (resume),
        .pc_we        (pc_we),
        .if_id_we     (if_id_we),
        .if_id_flush  (if_id_flush),
        .id_ex_bubble (id_ex_bubble),
        .halted       (halted),
        .state_dbg    (state_dbg)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cnt    (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       hz, rd, hd, rs;
        logic [4:0] exp;   // {pc_we, if_id_we, if_id_flush, id_ex_bubble, halted}
        logic [2:0] st;
    } vec_t;

    vec_t tbl[$];

    // Reference model: remaining FLUSH/DRAIN cycles and mode flags
    localparam int FC = 2;
    localparam int DC = 3;
    int m_flush, m_drain;
    bit m_halt, m_stall;

    task automatic add(input logic hz, rd, hd, rs, input logic [4:0] e, input logic [2:0] st);
        vec_t v;
        v.hz = hz; v.rd = rd; v.hd = hd; v.rs = rs; v.exp = e; v.st = st;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic hz, rd, hd, rs);
        data_hazard = hz; redirect = rd; halt_dec = hd; resume = rs;
    endtask

    function automatic logic [7:0] dut_vec();
        return {state_dbg, pc_we, if_id_we, if_id_flush, id_ex_bubble, halted};
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got state=%0d outs=%b, want state=%0d outs=%b",
                     nm, act[7:5], act[4:0], exp[7:5], exp[4:0]);
        end
    endtask

    function automatic logic [7:0] model_out(input logic hz, rd);
        if (m_halt)      return {3'd4, 5'b00111};
        if (m_drain > 0) return {3'd3, 5'b00110};
        if (m_flush > 0) return {3'd2, 5'b11110};
        return {(m_stall ? 3'd1 : 3'd0), rd | ~hz, ~hz, rd, rd | hz, 1'b0};
    endfunction

    task automatic model_step(input logic hz, rd, hd, rs);
        if (m_halt) begin
            if (rs) m_halt = 0;
        end else if (m_drain > 0) begin
            if (rd) begin
                m_drain = 0; m_flush = FC;
            end else begin
                m_drain--;
                if (m_drain == 0) m_halt = 1;
            end
        end else if (m_flush > 0) begin
            if (rd) m_flush = FC;
            else    m_flush--;
        end else if (m_stall) begin
            if (rd) begin
                m_stall = 0; m_flush = FC;
            end else if (!hz) begin
                m_stall = 0;
            end
        end else begin
            if (rd)      m_flush = FC;
            else if (hd) m_drain = DC;
            else if (hz) m_stall = 1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_flush = 0; m_drain = 0; m_halt = 0; m_stall = 0;
    endtask

    initial begin
        //      hz rd hd rs  outs      st
        add(0, 0, 0, 0, 5'b11000, 3'd0);
        add(1, 0, 0, 0, 5'b00010, 3'd0);
        add(1, 0, 0, 0, 5'b00010, 3'd1);
        add(1, 0, 0, 0, 5'b00010, 3'd1);
        add(0, 0, 0, 0, 5'b11000, 3'd1);
        add(0, 0, 0, 0, 5'b11000, 3'd0);
        add(0, 1, 0, 0, 5'b11110, 3'd0);
        add(1, 0, 0, 0, 5'b11110, 3'd2);
        add(1, 0, 1, 0, 5'b11110, 3'd2);
        add(0, 0, 0, 0, 5'b11000, 3'd0);
        add(0, 0, 1, 0, 5'b11000, 3'd0);
        add(0, 0, 0, 0, 5'b00110, 3'd3);
        add(0, 0, 0, 0, 5'b00110, 3'd3);
        add(0, 0, 0, 0, 5'b00110, 3'd3);
        add(1, 1, 1, 0, 5'b00111, 3'd4);
        add(0, 0, 0, 0, 5'b00111, 3'd4);
        add(0, 0, 0, 1, 5'b00111, 3'd4);
        add(0, 0, 0, 0, 5'b11000, 3'd0);
        add(0, 1, 1, 0, 5'b11110, 3'd0);
        add(0, 0, 0, 0, 5'b11110, 3'd2);
        add(0, 0, 0, 0, 5'b11110, 3'd2);
        add(0, 0, 0, 0, 5'b11000, 3'd0);
        add(0, 0, 1, 0, 5'b11000, 3'd0);
        add(0, 0, 0, 0, 5'b00110, 3'd3);
        add(0, 1, 0, 0, 5'b00110, 3'd3);
        add(0, 0, 0, 0, 5'b11110, 3'd2);
        add(0, 0, 0, 0, 5'b11110, 3'd2);
        add(0, 0, 0, 0, 5'b11000, 3'd0);
        add(1, 1, 0, 0, 5'b10110, 3'd0);
        add(0, 1, 0, 0, 5'b11110, 3'd2);
        add(0, 0, 0, 0, 5'b11110, 3'd2);
        add(0, 0, 0, 0, 5'b11110, 3'd2);
        add(0, 0, 0, 0, 5'b11000, 3'd0);
        add(1, 0, 0, 0, 5'b00010, 3'd0);
        add(1, 1, 0, 0, 5'b10110, 3'd1);
        add(0, 0, 0, 0, 5'b11110, 3'd2);
        add(0, 0, 0, 0, 5'b11110, 3'd2);
        add(0, 0, 0, 0, 5'b11000, 3'd0);
        add(1, 0, 0, 0, 5'b00010, 3'd0);
        add(1, 0, 1, 0, 5'b00010, 3'd1);
        add(0, 0, 0, 0, 5'b11000, 3'd1);
        add(0, 0, 0, 0, 5'b11000, 3'd0);

        // Reset values, including with live inputs held off by reset
        #1;
        chk("reset_idle", dut_vec(), {3'd0, 5'b00110});
        drive(1, 1, 1, 1);
        #2;
        chk("reset_inputs", dut_vec(), {3'd0, 5'b00110});
        @(posedge clk); #1;
        chk("reset_after_edge", dut_vec(), {3'd0, 5'b00110});
        drive(0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i].hz, tbl[i].rd, tbl[i].hd, tbl[i].rs);
            #2;
            chk($sformatf("vec%0d", i), dut_vec(), {tbl[i].st, tbl[i].exp});
        end

        // Asynchronous reset in the middle of a DRAIN
        @(negedge clk); drive(0, 0, 1, 0);
        @(negedge clk); drive(0, 0, 0, 0);
        #2;
        chk("drain_before_rst", dut_vec(), {3'd3, 5'b00110});
        rst_n = 1'b0;
        #1;
        chk("drain_async_rst", dut_vec(), {3'd0, 5'b00110});
        @(negedge clk); rst_n = 1'b1;
        #2;
        chk("drain_rst_release", dut_vec(), {3'd0, 5'b11000});
        @(negedge clk); #2;
        chk("drain_rst_run", dut_vec(), {3'd0, 5'b11000});

        // Asynchronous reset in the middle of a FLUSH
        @(negedge clk); drive(0, 1, 0, 0);
        @(negedge clk); drive(0, 0, 0, 0);
        #2;
        chk("flush_before_rst", dut_vec(), {3'd2, 5'b11110});
        rst_n = 1'b0;
        #1;
        chk("flush_async_rst", dut_vec(), {3'd0, 5'b00110});
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); #2;
        chk("flush_rst_run", dut_vec(), {3'd0, 5'b11000});

        // Randomized traffic against the reference model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic hz, rd, hd, rs;
            @(negedge clk);
            hz = ($urandom % 3) == 0;
            rd = ($urandom % 10) == 0;
            hd = ($urandom % 8) == 0;
            rs = ($urandom % 4) == 0;
            drive(hz, rd, hd, rs);
            #2;
            chk($sformatf("rand%0d", n), dut_vec(), model_out(hz, rd));
            @(posedge clk);
            model_step(hz, rd, hd, rs);
        end

`ifdef PIPE_PERF_CNT_EN
        do_reset();
        repeat (5) begin
            @(negedge clk); drive(1, 0, 0, 0);
        end
        @(negedge clk); drive(0, 0, 0, 0);
        @(negedge clk); drive(0, 0, 1, 0);
        @(negedge clk); drive(0, 0, 0, 0);
        repeat (6) @(negedge clk);
        checks++;
        if (stall_cnt !== 16'd8) begin
            failures++;
            $display("FAIL stall_cnt_8: got %0d want 8", stall_cnt);
        end
        drive(0, 0, 0, 1);
        @(negedge clk); drive(1, 0, 0, 0);
        force dut.stall_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.stall_cnt_q;
        @(negedge clk);
        checks++;
        if (stall_cnt !== 16'hFFFF) begin
            failures++;
            $display("FAIL stall_cnt_sat: got %0h want ffff", stall_cnt);
        end
        drive(0, 0, 0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_seq_ctrl.md
PIPE_SEQ_CTRL -- requirements
Module: pipe_seq_ctrl

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2: bubble cycles inserted after a PC redirect; legal range 1..7.
REQ-002 Parameter DRAIN_CYCLES, default 3: cycles to drain EX/MEM/WB after a decoded HALT; legal range 1..7.
REQ-003 clk  in  1  single global clock, rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 data_hazard  in  1  level from hazard detection in ID; valid same cycle.
REQ-006 redirect  in  1  single-cycle pulse; a taken branch, call or ret resolved this cycle.
REQ-007 halt_dec  in  1  single-cycle pulse; HALT decoded in ID.
REQ-008 resume  in  1  single-cycle pulse; PC update request that un-halts the pipe.
REQ-009 pc_we  out  1  PC register load enable.
REQ-010 if_id_we  out  1  IF/ID register load enable.
REQ-011 if_id_flush  out  1  IF/ID register clears to NOP.
REQ-012 id_ex_bubble  out  1  ID/EX control fields forced to NOP (RegWrite/MemWrite/MemRead/branch/call/ret = 0).
REQ-013 halted  out  1  pipe fully halted.
REQ-014 state_dbg  out  3  current state encoding.

Function
REQ-015 States RUN, STALL, FLUSH, DRAIN, HALT; a 3-bit down-counter cnt shared by FLUSH and DRAIN.
REQ-016 Input priority in every state: redirect > halt_dec > data_hazard; resume is honoured only in HALT.
REQ-017 RUN: redirect -> FLUSH with cnt=FLUSH_CYCLES-1; else halt_dec -> DRAIN with cnt=DRAIN_CYCLES-1; else data_hazard -> STALL; else remain in RUN.
REQ-018 STALL: redirect -> FLUSH; else !data_hazard -> RUN; else remain in STALL; halt_dec in STALL is ignored, because ID is frozen and re-presents the instruction.
REQ-019 FLUSH: cnt decrements each cycle; at cnt==0 -> RUN; halt_dec is ignored (wrong path); a new redirect reloads cnt=FLUSH_CYCLES-1.
REQ-020 DRAIN: cnt decrements each cycle; at cnt==0 -> HALT; a redirect cancels the drain -> FLUSH.
REQ-021 HALT: resume -> RUN on the next edge; all other inputs are ignored.
REQ-022 Outputs in RUN/STALL are combinational, same cycle: pc_we=redirect|!data_hazard; if_id_we=!data_hazard; if_id_flush=redirect; id_ex_bubble=redirect|data_hazard; halted=0.
REQ-023 Outputs in FLUSH: pc_we=1, if_id_we=1, if_id_flush=1, id_ex_bubble=1, halted=0.
REQ-024 Outputs in DRAIN: pc_we=0, if_id_we=0, if_id_flush=1, id_ex_bubble=1, halted=0.
REQ-025 Outputs in HALT: pc_we=0, if_id_we=0, if_id_flush=1, id_ex_bubble=1, halted=1.
REQ-026 halt_dec and redirect arriving in the same cycle resolve to FLUSH, and the HALT is discarded.
REQ-027 Unreachable state encodings recover to RUN on the next edge, with HALT-state outputs driven meanwhile.

Reset
REQ-028 While rst_n=0: state=RUN, cnt=0, pc_we=0, if_id_we=0, if_id_flush=1, id_ex_bubble=1, halted=0, state_dbg=RUN encoding.
REQ-029 When rst_n deasserts, RUN equations apply from the first clock edge; assertion mid-FLUSH or mid-DRAIN aborts that operation immediately.

Configuration
REQ-030 Macro PIPE_PERF_CNT_EN defined: adds output stall_cnt (16 bits), a saturating count of cycles in which pc_we=0 and state!=HALT, cleared by reset.
REQ-031 Macro PIPE_PERF_CNT_EN undefined: the stall_cnt port and its counter are absent, and all other behaviour is identical.

Structure
REQ-032 Package pipe_ctrl_pkg holds enum pipe_state_t (RUN=0, STALL=1, FLUSH=2, DRAIN=3, HALT=4) and the default constants FLUSH_CYCLES_DEF=2 and DRAIN_CYCLES_DEF=3.
REQ-033 One sub-module, cyc_down_cnt: a loadable 3-bit down-counter with a zero flag, used by FLUSH and DRAIN.

Verification
REQ-034 Hazard: data_hazard=1 for 3 cycles in RUN -> pc_we=0 and if_id_we=0 for exactly those 3 cycles, id_ex_bubble=1, then RUN.
REQ-035 Redirect: redirect pulse in RUN -> if_id_flush=1 that cycle plus 2 FLUSH cycles, then RUN; data_hazard during FLUSH has no effect.
REQ-036 Halt: halt_dec pulse -> 3 DRAIN cycles with pc_we=0, then halted=1 held; resume pulse -> RUN next cycle with halted=0.
REQ-037 Collision: halt_dec and redirect in the same cycle -> FLUSH, and halted never asserts; redirect during DRAIN cnt=1 -> FLUSH.
REQ-038 Reset: rst_n low mid-DRAIN -> outputs take reset values asynchronously, and state_dbg=RUN after release.
REQ-039 PIPE_PERF_CNT_EN: 5 stall cycles plus 3 drain cycles -> stall_cnt=8; forced 0xFFFF plus a stall -> stays 0xFFFF.
